ctrl_fsm: RTL and testbench
===========================

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 clk  in  1  rising-edge clock; the only clock.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 mem_rdata  in  32  instruction word; sampled only when ir_write=1.
REQ-004 mem_ready  in  1  memory completion for the current mem_read/mem_write request.
REQ-005 branch_taken  in  1  ALU branch/jump result; sampled in EXECUTE only.
REQ-006 alu_func  out  5  ALU operation code from the shared definition list.
REQ-007 alu_b_sel  out  1  1 = imm onto ALU B, 0 = rs2 data.
REQ-008 imm  out  32  sign-extended immediate of the latched instruction.
REQ-009 rs1, rs2, rd  out  5 each  register fields of the latched instruction.
REQ-010 ir_write, pc_write, reg_write, mem_read, mem_write  out  1 each  single-purpose strobes.
REQ-011 pc_src  out  1  0 = PC+4, 1 = PC+imm.
REQ-012 wb_sel  out  2  0 = ALU out, 1 = memory data, 2 = PC+4.
REQ-013 state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7.
REQ-014 illegal  out  1  high while in TRAP.

Function
REQ-015 Supported instructions: add, sub, and, or, xor, addi, andi, ori, xori, lw, sw, lui, beq, bne, blt, bge, jal. Any other opcode/funct3/funct7 combination is illegal.
REQ-016 FETCH: mem_read=1 until mem_ready=1; in that cycle ir_write=1 and next state is DECODE.
REQ-017 DECODE (1 cycle): latch rs1/rs2/rd/imm and compute alu_func; an illegal instruction goes to TRAP.
REQ-018 EXECUTE (1 cycle): alu_func held.
  - ALU and lui go to WB; lw/sw go to MEM.
  - Branch: pc_write=1, pc_src=branch_taken, then FETCH.
  - jal: ALU_JUMP, go to WB.
REQ-019 MEM: mem_read (lw) or mem_write (sw) held until mem_ready=1.
  - lw then goes to WB.
  - sw: pc_write=1, pc_src=0 in the mem_ready cycle, then FETCH.
REQ-020 WB (1 cycle): reg_write=1 unless rd=0.
  - wb_sel: 1 for lw, 2 for jal, 0 otherwise.
  - pc_write=1, pc_src=1 for jal, 0 otherwise; then FETCH.
REQ-021 pc_write SHALL pulse exactly once per retired instruction and never in TRAP.
REQ-022 Func mapping:
  - R-type: ALU_ADD/SUB/AND/OR/XOR, alu_b_sel=0.
  - I-type: ALU_ADDI/ANDI/ORI/XORI.
  - lw: ALU_LOAD with alu_b_sel=1. sw: ALU_STORE.
  - lui: ALU_LUI. Branches: ALU_BEQ/BNE/BLT/BGE.
  - Outside EXECUTE, alu_func SHALL equal ALU_ADD.
REQ-023 imm formats: I, S, B, U, J per RV32I, sign-extended to 32 bits; U is upper 20 bits with 12 zero bits.
REQ-024 Zero-wait latency in cycles: ALU/lui 4, jal 4, lw 5, sw 4, branch 3.
REQ-025 mem_ready outside FETCH/MEM, or while no request is active, SHALL be ignored.
REQ-026 TRAP is absorbing: all strobes 0, illegal=1, until rst.

Reset
REQ-027 rst SHALL force state=FETCH on the next edge, even mid-instruction and even during a pending memory request.
REQ-028 Registered outputs SHALL clear to 0 on reset: rs1, rs2, rd, imm, and illegal.
REQ-029 The cycle after reset SHALL show mem_read=1 and all other strobes 0.

Configuration
REQ-030 CTRL_MEM_HANDSHAKE_EN defined: FETCH and MEM wait on mem_ready as specified.
REQ-031 CTRL_MEM_HANDSHAKE_EN undefined: mem_ready is ignored and FETCH and MEM each take exactly 1 cycle.

Structure
REQ-032 ALU_* func codes, opcode constants and state encodings SHALL live in the shared definition list included by both ALU and ctrl_fsm.
REQ-033 Immediate extraction SHALL be a combinational sub-module imm_gen, instantiated once.

Verification
REQ-034 Bench SHALL cover all scenarios below; mem_ready tied 1 unless stated.
  - rst, then mem_rdata=0x00500093 (addi x1,x0,5): states 0,1,2,4; alu_func=ALU_ADDI, imm=5, rd=1; reg_write and pc_write in WB.
  - 0x0000A283 (lw x5,0(x1)) with mem_ready low 3 cycles in MEM: mem_read held 4 MEM cycles; WB wb_sel=1, rd=5.
  - 0x00000463 (beq x0,x0,8), branch_taken=1: imm=8, pc_write=1 and pc_src=1 in EXECUTE, back in FETCH at cycle 4.
  - 0x0050A223 (sw x5,4(x1)): alu_func=ALU_STORE, imm=4, mem_write=1, reg_write never asserted.
  - 0x00000000: TRAP reached after DECODE, illegal=1, no pc_write; rst then returns to FETCH.
  - rst asserted in MEM of a load: FETCH next cycle, no reg_write.

Source files
------------

// File: rtl/ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_pkg -- shared definition list for the multi-cycle RV32I subset
// control path. Holds the ALU function codes (also consumed by the ALU),
// opcode constants, FSM state encodings, write-back select codes and the
// instruction decoder used in DECODE.
//
// Supported instructions: add, sub, and, or, xor, addi, andi, ori, xori,
// lw, sw, lui, beq, bne, blt, bge, jal. Everything else decodes as illegal.
// ---------------------------------------------------------------------------
package ctrl_fsm_pkg;

  // FSM state encoding; visible on the state output of ctrl_fsm.
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd7
  } state_e;

  // ALU operation codes shared with the ALU.
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_ADDI  = 5'd5,
    ALU_ANDI  = 5'd6,
    ALU_ORI   = 5'd7,
    ALU_XORI  = 5'd8,
    ALU_LOAD  = 5'd9,
    ALU_STORE = 5'd10,
    ALU_LUI   = 5'd11,
    ALU_BEQ   = 5'd12,
    ALU_BNE   = 5'd13,
    ALU_BLT   = 5'd14,
    ALU_BGE   = 5'd15,
    ALU_JUMP  = 5'd16
  } alu_func_e;

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Write-back mux select codes.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Instruction class decides the EXECUTE/MEM/WB path.
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LUI    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5
  } instr_cls_e;

  // Immediate layout selector for imm_gen.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic       legal;
    instr_cls_e cls;
    alu_func_e  func;
    logic       b_sel;
    imm_fmt_e   fmt;
  } decode_t;

  // Full decode of one instruction word. Any unlisted opcode/funct3/funct7
  // combination leaves legal=0.
  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t    d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc     = instr[6:0];
    f3      = instr[14:12];
    f7      = instr[31:25];
    d.legal = 1'b0;
    d.cls   = CLS_ALU;
    d.func  = ALU_ADD;
    d.b_sel = 1'b0;
    d.fmt   = IMM_NONE;
    case (opc)
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          d.legal = 1'b1;
          case (f3)
            3'b000:  d.func = ALU_ADD;
            3'b111:  d.func = ALU_AND;
            3'b110:  d.func = ALU_OR;
            3'b100:  d.func = ALU_XOR;
            default: d.legal = 1'b0;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d.legal = 1'b1;
          d.func  = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        d.legal = 1'b1;
        d.b_sel = 1'b1;
        d.fmt   = IMM_I;
        case (f3)
          3'b000:  d.func = ALU_ADDI;
          3'b111:  d.func = ALU_ANDI;
          3'b110:  d.func = ALU_ORI;
          3'b100:  d.func = ALU_XORI;
          default: d.legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d.legal = (f3 == 3'b010);
        d.cls   = CLS_LOAD;
        d.func  = ALU_LOAD;
        d.b_sel = 1'b1;
        d.fmt   = IMM_I;
      end
      OPC_STORE: begin
        d.legal = (f3 == 3'b010);
        d.cls   = CLS_STORE;
        d.func  = ALU_STORE;
        d.b_sel = 1'b1;
        d.fmt   = IMM_S;
      end
      OPC_LUI: begin
        d.legal = 1'b1;
        d.cls   = CLS_LUI;
        d.func  = ALU_LUI;
        d.b_sel = 1'b1;
        d.fmt   = IMM_U;
      end
      OPC_BRANCH: begin
        d.legal = 1'b1;
        d.cls   = CLS_BRANCH;
        d.fmt   = IMM_B;
        case (f3)
          3'b000:  d.func = ALU_BEQ;
          3'b001:  d.func = ALU_BNE;
          3'b100:  d.func = ALU_BLT;
          3'b101:  d.func = ALU_BGE;
          default: d.legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        d.legal = 1'b1;
        d.cls   = CLS_JAL;
        d.func  = ALU_JUMP;
        d.b_sel = 1'b1;
        d.fmt   = IMM_J;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctrl_fsm_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen -- combinational RV32I immediate extraction.
//
// Ports:
//   instr_i  in  32  instruction word
//   fmt_i    in  3   immediate layout (I, S, B, U, J or none)
//   imm_o    out 32  sign-extended immediate; U keeps the upper 20 bits with
//                    12 zero bits below; "none" yields 0
// ---------------------------------------------------------------------------
module imm_gen
  import ctrl_fsm_pkg::*;
(
  input  logic [31:0] instr_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ctrl_fsm -- multi-cycle control FSM for an RV32I subset.
// FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB] -> FETCH, TRAP on illegal.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   mem_rdata    in 32  instruction word, captured only when ir_write=1
//   mem_ready    in 1   completion of the current mem_read/mem_write
//   branch_taken in 1   ALU branch result, used in EXECUTE only
//   alu_func     out 5  ALU op (ALU_ADD outside EXECUTE)
//   alu_b_sel    out 1  1 = imm onto ALU B, 0 = rs2
//   imm          out 32 immediate of the latched instruction
//   rs1/rs2/rd   out 5  register fields of the latched instruction
//   ir_write, pc_write, reg_write, mem_read, mem_write  out 1  strobes
//   pc_src       out 1  0 = PC+4, 1 = PC+imm
//   wb_sel       out 2  0 = ALU, 1 = memory, 2 = PC+4
//   state        out 3  current FSM state (debug/observation)
//   illegal      out 1  high while in TRAP
//
// Memory handshake: mem_read/mem_write are requests held high until the
// cycle in which mem_ready=1 completes them; mem_ready is ignored whenever
// no request is being raised.
//
// Configuration: define CTRL_MEM_HANDSHAKE_EN to make FETCH and MEM wait on
// mem_ready. Without it mem_ready is ignored and FETCH and MEM each last
// exactly one cycle.
// ---------------------------------------------------------------------------
module ctrl_fsm
  import ctrl_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic [4:0]  alu_func,
  output logic        alu_b_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_src,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] imm_q;
  logic [31:0] imm_d;
  alu_func_e   func_q;
  instr_cls_e  cls_q;
  logic        b_sel_q;
  logic        illegal_q;
  logic        mem_done;
  decode_t     dec;

`ifdef CTRL_MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  // Memory is treated as single-cycle; mem_ready is deliberately unused.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  // Decode always looks at the instruction register, so DECODE sees the
  // word captured at the end of FETCH, never the live bus.
  assign dec = decode_instr(ir_q);

  imm_gen u_imm_gen (
    .instr_i (ir_q),
    .fmt_i   (dec.fmt),
    .imm_o   (imm_d)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_d == ST_TRAP);
    end
  end

  // Instruction register and fields latched in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      func_q  <= ALU_ADD;
      cls_q   <= CLS_ALU;
      b_sel_q <= 1'b0;
    end else begin
      if (ir_write) begin
        ir_q <= mem_rdata;
      end
      if (state_q == ST_DECODE) begin
        rs1_q   <= ir_q[19:15];
        rs2_q   <= ir_q[24:20];
        rd_q    <= ir_q[11:7];
        imm_q   <= imm_d;
        func_q  <= dec.func;
        cls_q   <= dec.cls;
        b_sel_q <= dec.b_sel;
      end
    end
  end

  // Next-state and strobe logic.
  always_comb begin
    state_d   = state_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_src    = 1'b0;
    wb_sel    = WB_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_done) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = dec.legal ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            // Branches retire here: this is their only pc_write.
            pc_write = 1'b1;
            pc_src   = branch_taken;
            state_d  = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (cls_q == CLS_LOAD) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
        end
        if (mem_done) begin
          if (cls_q == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            // Stores retire in their completing MEM cycle.
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        reg_write = (rd_q != 5'd0);
        pc_write  = 1'b1;
        pc_src    = (cls_q == CLS_JAL);
        if (cls_q == CLS_LOAD) begin
          wb_sel = WB_MEM;
        end else if (cls_q == CLS_JAL) begin
          wb_sel = WB_PC4;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        // Unused encodings recover to FETCH.
        state_d = ST_FETCH;
      end
    endcase
  end

  assign alu_func  = (state_q == ST_EXECUTE) ? func_q : ALU_ADD;
  assign alu_b_sel = b_sel_q;
  assign imm       = imm_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign state     = state_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_ctrl_fsm -- directed bench for ctrl_fsm. Each driven cycle pushes its
// expected output snapshot (and a care mask) into a queue; a monitor on the
// falling edge pops and compares against the DUT outputs.
// Snapshot layout: {state, illegal, ir_write, pc_write, reg_write, mem_read,
// mem_write, pc_src, wb_sel, alu_func, alu_b_sel, rd, rs1, rs2, imm}.
// ---------------------------------------------------------------------------
module tb_ctrl_fsm;

  localparam int W = 65;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2,
                         S_M = 3'd3, S_W = 3'd4, S_T = 3'd7;

  localparam logic [4:0] F_ADD = 5'd0, F_SUB = 5'd1, F_ADDI = 5'd5,
                         F_LOAD = 5'd9, F_STORE = 5'd10, F_LUI = 5'd11,
                         F_BEQ = 5'd12, F_BNE = 5'd13, F_JUMP = 5'd16;

  // Strobes {illegal, ir_write, pc_write, reg_write, mem_read, mem_write, pc_src}
  localparam logic [6:0] SB_NONE  = 7'b0000000;
  localparam logic [6:0] SB_FETCH = 7'b0100100;
  localparam logic [6:0] SB_WB    = 7'b0011000;
  localparam logic [6:0] SB_PCW   = 7'b0010000;
  localparam logic [6:0] SB_JALWB = 7'b0011001;
  localparam logic [6:0] SB_BR_T  = 7'b0010001;
  localparam logic [6:0] SB_MR    = 7'b0000100;
  localparam logic [6:0] SB_SW    = 7'b0010010;
  localparam logic [6:0] SB_TRAP  = 7'b1000000;

  localparam logic [W-1:0] M_ALL  = {W{1'b1}};
  localparam logic [W-1:0] M_CTRL = {17'h1FFFF, 48'h0};
  localparam logic [W-1:0] M_NOB  = M_ALL & ~(65'h1 << 47);

`ifdef CTRL_MEM_HANDSHAKE_EN
  localparam logic MEM_LAST_RDY = 1'b1;
`else
  localparam logic MEM_LAST_RDY = 1'b0;
`endif

  // Clock / reset / DUT
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        branch_taken;
  logic [4:0]  alu_func;
  logic        alu_b_sel;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        ir_write, pc_write, reg_write, mem_read, mem_write, pc_src;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        illegal;

  always #5 clk = ~clk;

  ctrl_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .alu_func     (alu_func),
    .alu_b_sel    (alu_b_sel),
    .imm          (imm),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .pc_src       (pc_src),
    .wb_sel       (wb_sel),
    .state        (state),
    .illegal      (illegal)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        name_q[$];
  int           n_chk  = 0;
  int           n_fail = 0;

  function automatic logic [W-1:0] pk(input logic [2:0] st, input logic [6:0] sb,
                                      input logic [1:0] wbs, input logic [4:0] fn,
                                      input logic bs, input logic [4:0] f_rd,
                                      input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                                      input logic [31:0] f_imm);
    return {st, sb, wbs, fn, bs, f_rd, f_rs1, f_rs2, f_imm};
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] act, e, m;
      string        nm;
      e  = exp_q.pop_front();
      m  = msk_q.pop_front();
      nm = name_q.pop_front();
      act = {state, illegal, ir_write, pc_write, reg_write, mem_read, mem_write,
             pc_src, wb_sel, alu_func, alu_b_sel, rd, rs1, rs2, imm};
      n_chk++;
      if (((act ^ e) & m) !== '0) begin
        n_fail++;
        $display("FAIL %s: got %h required %h (care mask %h)", nm, act, e, m);
      end
    end
  end

  // Driver: one call = one clock cycle of inputs plus its expected outputs.
  task automatic step(input logic r, input logic [31:0] rdat, input logic rdy,
                      input logic tk, input logic chk, input logic [W-1:0] e,
                      input logic [W-1:0] m, input string nm);
    rst          = r;
    mem_rdata    = rdat;
    mem_ready    = rdy;
    branch_taken = tk;
    if (chk) begin
      exp_q.push_back(e);
      msk_q.push_back(m);
      name_q.push_back(nm);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // FETCH then DECODE; the bus is zeroed in DECODE so only the captured word counts.
  task automatic fetch_dec(input string nm, input logic [31:0] ins, input logic [W-1:0] m);
    step(1'b0, ins, 1'b1, 1'b0, 1'b1, pk(S_F, SB_FETCH, 2'd0, F_ADD, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0),
         m, {nm, "_fetch"});
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_D, SB_NONE, 2'd0, F_ADD, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0),
         m, {nm, "_decode"});
  endtask

  initial begin
    rst = 1'b1; mem_rdata = '0; mem_ready = 1'b1; branch_taken = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, '0, '0, "reset");
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, '0, '0, "reset");

    // addi x1,x0,5 -- reset values checked in FETCH/DECODE
    fetch_dec("addi", 32'h00500093, M_NOB);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_E, SB_NONE, 2'd0, F_ADDI, 1'b1, 5'd1, 5'd0, 5'd5, 32'd5), M_ALL, "addi_exec");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_W, SB_WB, 2'd0, F_ADD, 1'b0, 5'd1, 5'd0, 5'd5, 32'd5), M_NOB, "addi_wb");

    // lw x5,0(x1) with mem_ready low for 3 MEM cycles
    fetch_dec("lw", 32'h0000A283, M_CTRL);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_E, SB_NONE, 2'd0, F_LOAD, 1'b1, 5'd5, 5'd1, 5'd0, 32'd0), M_ALL, "lw_exec");
`ifdef CTRL_MEM_HANDSHAKE_EN
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pk(S_M, SB_MR, 2'd0, F_ADD, 1'b0, 5'd5, 5'd1, 5'd0, 32'd0), M_NOB, "lw_mem_wait");
`endif
    step(1'b0, 32'h0, MEM_LAST_RDY, 1'b0, 1'b1, pk(S_M, SB_MR, 2'd0, F_ADD, 1'b0, 5'd5, 5'd1, 5'd0, 32'd0), M_NOB, "lw_mem_done");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_W, SB_WB, 2'd1, F_ADD, 1'b0, 5'd5, 5'd1, 5'd0, 32'd0), M_NOB, "lw_wb");

    // beq x0,x0,8 taken; next FETCH is checked by the following instruction
    fetch_dec("beq", 32'h00000463, M_CTRL);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, pk(S_E, SB_BR_T, 2'd0, F_BEQ, 1'b0, 5'd8, 5'd0, 5'd0, 32'd8), M_ALL, "beq_exec");

    // bne x0,x0,8 not taken
    fetch_dec("bne", 32'h00001463, M_CTRL);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_E, SB_PCW, 2'd0, F_BNE, 1'b0, 5'd8, 5'd0, 5'd0, 32'd8), M_ALL, "bne_exec");

    // sw x5,4(x1)
    fetch_dec("sw", 32'h0050A223, M_CTRL);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_E, SB_NONE, 2'd0, F_STORE, 1'b1, 5'd4, 5'd1, 5'd5, 32'd4), M_ALL, "sw_exec");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_M, SB_SW, 2'd0, F_ADD, 1'b0, 5'd4, 5'd1, 5'd5, 32'd4), M_NOB, "sw_mem");

    // jal x1,8
    fetch_dec("jal", 32'h008000EF, M_CTRL);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_E, SB_NONE, 2'd0, F_JUMP, 1'b1, 5'd1, 5'd0, 5'd8, 32'd8), M_ALL, "jal_exec");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_W, SB_JALWB, 2'd2, F_ADD, 1'b0, 5'd1, 5'd0, 5'd8, 32'd8), M_NOB, "jal_wb");

    // sub x0,x1,x2 -- rd=0 suppresses reg_write
    fetch_dec("sub", 32'h40208033, M_CTRL);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_E, SB_NONE, 2'd0, F_SUB, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0), M_ALL, "sub_exec");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_W, SB_PCW, 2'd0, F_ADD, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0), M_NOB, "sub_wb");

    // lui x5,0x12345
    fetch_dec("lui", 32'h123452B7, M_CTRL);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_E, SB_NONE, 2'd0, F_LUI, 1'b1, 5'd5, 5'd8, 5'd3, 32'h12345000), M_ALL, "lui_exec");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_W, SB_WB, 2'd0, F_ADD, 1'b0, 5'd5, 5'd8, 5'd3, 32'h12345000), M_NOB, "lui_wb");

    // illegal word: TRAP is absorbing even with mem_ready/branch_taken high
    fetch_dec("ill", 32'h00000000, M_CTRL);
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h00500093, 1'b1, 1'b1, 1'b1, pk(S_T, SB_TRAP, 2'd0, F_ADD, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0), M_CTRL, "trap_hold");
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_T, SB_TRAP, 2'd0, F_ADD, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0), M_CTRL, "trap_rst");

    // lw again from reset, with reset hitting its pending MEM request
    fetch_dec("lw_r", 32'h0000A283, M_NOB);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_E, SB_NONE, 2'd0, F_LOAD, 1'b1, 5'd5, 5'd1, 5'd0, 32'd0), M_ALL, "lw_r_exec");
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, pk(S_M, SB_MR, 2'd0, F_ADD, 1'b0, 5'd5, 5'd1, 5'd0, 32'd0), M_NOB, "lw_r_mem_rst");
    step(1'b0, 32'h00500093, 1'b1, 1'b0, 1'b1, pk(S_F, SB_FETCH, 2'd0, F_ADD, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0), M_NOB, "post_rst_fetch");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, pk(S_D, SB_NONE, 2'd0, F_ADD, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0), M_NOB, "post_rst_decode");

    // Every pushed expectation must have been consumed by the monitor.
    @(negedge clk); #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
